alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one multi-cycle ALU between two requesters.
// Defining ALU_TIMEOUT_EN adds a BUSY watchdog that aborts after TIMEOUT cycles.
module alu_arbiter #(
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned OP_W    = 6,
    localparam int unsigned D_W     = 16,
    localparam int unsigned F_W     = 4,
    localparam int unsigned N_REQ   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [OP_W-1:0]  op0,
    input  logic [OP_W-1:0]  op1,
    input  logic [D_W-1:0]   a0,
    input  logic [D_W-1:0]   b0,
    input  logic [D_W-1:0]   a1,
    input  logic [D_W-1:0]   b1,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic [D_W-1:0]   res1,
    output logic [D_W-1:0]   res2,
    output logic [F_W-1:0]   flags,
    output logic             err,
    output logic             alu_bgn,
    output logic [OP_W-1:0]  alu_op,
    output logic [D_W-1:0]   alu_a,
    output logic [D_W-1:0]   alu_b,
    input  logic [D_W-1:0]   alu_acc1,
    input  logic [D_W-1:0]   alu_acc2,
    input  logic [F_W-1:0]   alu_flags,
    input  logic             alu_rdy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;
    logic   prio;
    logic   owner;
    logic   winner_c;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("alu_arbiter: TIMEOUT must be at least 2");
    end

`ifdef ALU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] busy_cnt;
`endif

    // Lone requester wins outright; on contention the favoured requester wins.
    assign winner_c = (req == 2'b11) ? prio : req[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            owner   <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            res1    <= '0;
            res2    <= '0;
            flags   <= '0;
            err     <= 1'b0;
            alu_bgn <= 1'b0;
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
`ifdef ALU_TIMEOUT_EN
            busy_cnt <= '0;
`endif
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner   <= winner_c;
                        prio    <= ~winner_c;
                        gnt     <= {winner_c, ~winner_c};
                        alu_op  <= winner_c ? op1 : op0;
                        alu_a   <= winner_c ? a1  : a0;
                        alu_b   <= winner_c ? b1  : b0;
                        alu_bgn <= 1'b1;
`ifdef ALU_TIMEOUT_EN
                        busy_cnt <= '0;
`endif
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (alu_rdy) begin
                        res1    <= alu_acc1;
                        res2    <= alu_acc2;
                        flags   <= alu_flags;
                        err     <= 1'b0;
                        done    <= {owner, ~owner};
                        alu_bgn <= 1'b0;
                        state   <= RELEASE;
                    end
`ifdef ALU_TIMEOUT_EN
                    // A ready arriving on the last allowed cycle still completes normally.
                    else if (busy_cnt == CNT_W'(TIMEOUT - 1)) begin
                        res1    <= '0;
                        res2    <= '0;
                        flags   <= '0;
                        err     <= 1'b1;
                        done    <= {owner, ~owner};
                        alu_bgn <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
`endif
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model.
// Define ALU_TIMEOUT_EN for both files to exercise the BUSY watchdog (TIMEOUT=8).
module tb_alu_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [5:0]  op0 = '0, op1 = '0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  gnt, done;
    logic [15:0] res1, res2;
    logic [3:0]  flags;
    logic        err, alu_bgn;
    logic [5:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_acc1 = '0, alu_acc2 = '0;
    logic [3:0]  alu_flags = '0;
    logic        alu_rdy = 1'b0;

    alu_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .done(done), .res1(res1), .res2(res2), .flags(flags), .err(err),
        .alu_bgn(alu_bgn), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_acc1(alu_acc1), .alu_acc2(alu_acc2), .alu_flags(alu_flags), .alu_rdy(alu_rdy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_gnt  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference ALU: ADD=0, SUB=1, anything else XOR; flags {ovf, carry, neg, zero}.
    function automatic void alu_fn(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r1, output logic [15:0] r2, output logic [3:0] f);
        logic [16:0] s;
        logic c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            6'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r1 = s[15:0];
                c  = s[16];
                v  = (a[15] == b[15]) && (r1[15] != a[15]);
            end
            6'd1: begin
                r1 = a - b;
                c  = (a < b);
                v  = (a[15] != b[15]) && (r1[15] != a[15]);
            end
            default: r1 = a ^ b;
        endcase
        r2 = {a[7:0], b[7:0]} ^ {10'd0, op};
        f  = {v, c, r1[15], r1 == 16'd0};
    endfunction

    // Stub ALU: answers a begin after alu_fix (or random) cycles; may pulse rdy spuriously when idle.
    int alu_fix  = -1;
    bit alu_mute = 1'b0;
    bit alu_spur = 1'b0;
    bit alu_run  = 1'b0;
    bit alu_gave = 1'b0;
    int alu_wait = 0;

    always @(negedge clk) begin
        if (alu_bgn === 1'b1) begin
            if (alu_mute) begin
                alu_rdy = 1'b0;
                alu_run = 1'b0;
            end else begin
                if (!alu_run) begin
                    alu_run  = 1'b1;
                    alu_gave = 1'b0;
                    alu_wait = (alu_fix >= 0) ? alu_fix : int'($urandom_range(0, 4));
                end
                if (!alu_gave && alu_wait == 0) begin
                    alu_fn(alu_op, alu_a, alu_b, alu_acc1, alu_acc2, alu_flags);
                    alu_rdy  = 1'b1;
                    alu_gave = 1'b1;
                end else begin
                    alu_rdy = 1'b0;
                    if (alu_wait > 0) alu_wait--;
                end
            end
        end else begin
            alu_run   = 1'b0;
            alu_gave  = 1'b0;
            alu_rdy   = alu_spur && ($urandom_range(0, 3) == 0);
            alu_acc1  = 16'($urandom);
            alu_acc2  = 16'($urandom);
            alu_flags = 4'($urandom);
        end
    end

    // Transaction model: one operation in flight at a time, next grant >= 2 edges after completion.
    bit          m_busy  = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last  = 1'b1;
    bit          m_w;
    int          m_k     = 0;
    int          m_free  = 0;
    logic [1:0]  exp_gnt, exp_done;
    logic        exp_bgn, exp_err;
    logic [5:0]  exp_op;
    logic [15:0] exp_a, exp_b, exp_r1, exp_r2;
    logic [3:0]  exp_f;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_free = 0;
            exp_gnt = '0; exp_done = '0; exp_bgn = 1'b0; exp_err = 1'b0;
            exp_op = '0; exp_a = '0; exp_b = '0; exp_r1 = '0; exp_r2 = '0; exp_f = '0;
        end else begin
            exp_gnt  = '0;
            exp_done = '0;
            if (m_busy) begin
                m_k++;
                if (alu_rdy) begin
                    alu_fn(exp_op, exp_a, exp_b, exp_r1, exp_r2, exp_f);
                    exp_err  = 1'b0;
                    exp_done = m_owner ? 2'b10 : 2'b01;
                    exp_bgn  = 1'b0;
                    m_busy   = 1'b0;
                    m_free   = cyc + 2;
                end
`ifdef ALU_TIMEOUT_EN
                else if (m_k == TMO) begin
                    exp_r1 = '0; exp_r2 = '0; exp_f = '0; exp_err = 1'b1;
                    exp_done = m_owner ? 2'b10 : 2'b01;
                    exp_bgn  = 1'b0;
                    m_busy   = 1'b0;
                    m_free   = cyc + 2;
                end
`endif
            end else if (cyc >= m_free && req != 2'b00) begin
                m_w     = (req == 2'b11) ? !m_last : req[1];
                m_last  = m_w;
                m_owner = m_w;
                m_busy  = 1'b1;
                m_k     = 0;
                exp_gnt = m_w ? 2'b10 : 2'b01;
                exp_bgn = 1'b1;
                exp_op  = m_w ? op1 : op0;
                exp_a   = m_w ? a1 : a0;
                exp_b   = m_w ? b1 : b0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt",     16'(gnt),     16'(exp_gnt));
            chk("done",    16'(done),    16'(exp_done));
            chk("alu_bgn", 16'(alu_bgn), 16'(exp_bgn));
            chk("alu_op",  16'(alu_op),  16'(exp_op));
            chk("alu_a",   alu_a,        exp_a);
            chk("alu_b",   alu_b,        exp_b);
            chk("res1",    res1,         exp_r1);
            chk("res2",    res2,         exp_r2);
            chk("flags",   16'(flags),   16'(exp_f));
            chk("err",     16'(err),     16'(exp_err));
            if (gnt != 2'b00) n_gnt++;
        end
    end

    task automatic wait_gnt(output int c, output logic [1:0] g);
        c = -1; g = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin c = cyc; g = gnt; break; end
        end
        if (c < 0) begin
            n_chk++; n_fail++;
            $display("FAIL wait_gnt: no grant within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_done(output int c, output logic [1:0] d);
        c = -1; d = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin c = cyc; d = done; break; end
        end
        if (c < 0) begin
            n_chk++; n_fail++;
            $display("FAIL wait_done: no done within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_ops(input int i);
        logic [5:0] o;
        o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 1));
        if (i == 0) begin op0 = o; a0 = 16'($urandom); b0 = 16'($urandom); end
        else        begin op1 = o; a1 = 16'($urandom); b1 = 16'($urandom); end
    endtask

    // Requester agents: 0 idle, 1 waiting for grant, 2 granted (operands may change, req may drop).
    int ag[2] = '{0, 0};

    task automatic agent_step(input bit allow_raise);
        for (int i = 0; i < 2; i++) begin
            case (ag[i])
                0: if (allow_raise && $urandom_range(0, 3) == 0) begin
                       set_ops(i); req[i] = 1'b1; ag[i] = 1;
                   end
                1: if (gnt[i]) begin ag[i] = 2; set_ops(i); end
                default: if (done[i]) begin
                       req[i] = 1'b0; ag[i] = 0;
                   end else begin
                       if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                       set_ops(i);
                   end
            endcase
        end
    endtask

    int gc, dc, rc, pdc, nd;
    logic [1:0]  g, d, want;
    logic        d_err;
    logic [15:0] d_r1;

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("rst_gnt",   16'(gnt),     16'd0);
        chk("rst_done",  16'(done),    16'd0);
        chk("rst_bgn",   16'(alu_bgn), 16'd0);
        chk("rst_res1",  res1,         16'd0);
        chk("rst_flags", 16'(flags),   16'd0);
        chk("rst_err",   16'(err),     16'd0);
        chk("rst_alu_a", alu_a,        16'd0);

        // Single ADD 5+3.
        alu_fix = 3; op0 = 6'd0; a0 = 16'd5; b0 = 16'd3; req = 2'b01;
        wait_gnt(gc, g);
        chk("add_gnt", 16'(g), 16'b01);
        wait_done(dc, d);
        req = 2'b00;
        chk("add_done",  16'(d),     16'b01);
        chk("add_res1",  res1,       16'd8);
        chk("add_flags", 16'(flags), 16'd0);
        chk("add_err",   16'(err),   16'd0);
        chk("add_lat",   16'(dc - gc), 16'd4);
        @(negedge clk);
        chk("add_done_pulse", 16'(done), 16'd0);

        // SUB 7-7 sets only zero.
        op0 = 6'd1; a0 = 16'd7; b0 = 16'd7; req = 2'b01;
        wait_gnt(gc, g);
        wait_done(dc, d);
        req = 2'b00;
        chk("sub_res1",  res1,       16'd0);
        chk("sub_flags", 16'(flags), 16'b0001);

        // Both requesting from reset alternate 0,1,0,1.
        do_reset();
        alu_fix = 1;
        op0 = 6'd0; a0 = 16'd1; b0 = 16'd2; op1 = 6'd1; a1 = 16'd9; b1 = 16'd4;
        req = 2'b11;
        pdc = 0;
        for (int k = 0; k < 4; k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_gnt(gc, g);
            chk("rr_order", 16'(g), 16'(want));
            if (k > 0) chk("rr_gap", 16'(gc - pdc), 16'd2);
            wait_done(dc, d);
            chk("rr_done_owner", 16'(d), 16'(g));
            pdc = dc;
        end
        req = 2'b00;

        // Late request from requester 1 while 0 is busy.
        do_reset();
        alu_fix = 2; op0 = 6'd0; a0 = 16'd10; b0 = 16'd20; op1 = 6'd0; a1 = 16'd3; b1 = 16'd4;
        req = 2'b01;
        wait_gnt(gc, g);
        req = 2'b11;
        wait_done(dc, d);
        req = 2'b10;
        chk("late_done0", 16'(d), 16'b01);
        wait_gnt(gc, g);
        chk("late_gnt1", 16'(g), 16'b10);
        chk("late_gap",  16'(gc - dc), 16'd2);
        wait_done(dc, d);
        req = 2'b00;
        chk("late_res1", res1, 16'd7);

        // Reset during BUSY abandons the operation.
        alu_fix = 5; op1 = 6'd0; a1 = 16'h1234; b1 = 16'h0001;
        req = 2'b01;
        wait_gnt(gc, g);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_gnt",   16'(gnt),     16'd0);
        chk("mid_done",  16'(done),    16'd0);
        chk("mid_bgn",   16'(alu_bgn), 16'd0);
        chk("mid_res1",  res1,         16'd0);
        chk("mid_res2",  res2,         16'd0);
        chk("mid_flags", 16'(flags),   16'd0);
        chk("mid_err",   16'(err),     16'd0);
        chk("mid_op",    16'(alu_op),  16'd0);
        chk("mid_a",     alu_a,        16'd0);
        chk("mid_b",     alu_b,        16'd0);
        rst = 1'b0;
        req = 2'b10;
        rc = cyc;
        wait_gnt(gc, g);
        chk("post_gnt",   16'(g), 16'b10);
        chk("post_lat",   16'(gc - rc), 16'd1);
        chk("post_alu_a", alu_a, 16'h1234);
        wait_done(dc, d);
        req = 2'b00;
        chk("post_res1", res1, 16'h1235);

        // ALU that never answers.
        alu_mute = 1'b1;
        req = 2'b01;
        wait_gnt(gc, g);
        nd = 0; dc = -1; d_err = 1'b0; d_r1 = 16'hffff;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                nd++;
                if (dc < 0) begin dc = cyc; d_err = err; d_r1 = res1; end
            end
        end
`ifdef ALU_TIMEOUT_EN
        chk("tmo_done_cnt", 16'(nd),      16'd1);
        chk("tmo_err",      16'(d_err),   16'd1);
        chk("tmo_res1",     d_r1,         16'd0);
        chk("tmo_lat",      16'(dc - gc), 16'(TMO));
`else
        chk("hang_done_cnt", 16'(nd),      16'd0);
        chk("hang_bgn",      16'(alu_bgn), 16'd1);
`endif
        req = 2'b00;
        alu_mute = 1'b0;
        do_reset();

        // Randomized traffic with spurious ALU ready pulses.
        alu_fix = -1;
        alu_spur = 1'b1;
        n_gnt = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            agent_step(1'b1);
        end
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            agent_step(1'b0);
            if (ag[0] == 0 && ag[1] == 0) break;
        end
        chk("drain_idle",    16'(ag[0] + ag[1]), 16'd0);
        chk("rand_activity", 16'(n_gnt > 100),   16'd1);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
